// File: rtl/mskkey_load_ctrl.sv
// mskkey_load_ctrl: sequences a masked key load into the key holder.
// Accepts a load command, waits for holder and AES core to go idle, pulses the
// holder's start, forwards d*N key words, then waits for the holder to finish.
// AES start requests are gated for the whole load, except that the inverse-mode
// last-round-key computation may start while the holder asks for it.
// Optional feature: define KEYLOAD_LOCK_EN to add the sticky `lock` input.
module mskkey_load_ctrl #(
  parameter int unsigned d = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_key_size,
  input  logic        cmd_mode_inverse,
  input  logic [31:0] key_data,
  input  logic        key_valid,
  output logic        key_ready,
  output logic        holder_start_fetch,
  output logic [1:0]  holder_key_size_cfg,
  output logic        holder_mode_inverse,
  output logic [31:0] holder_data_in,
  output logic        holder_data_in_valid,
  input  logic        holder_data_in_ready,
  input  logic        holder_busy,
  input  logic        holder_last_key_req,
  input  logic        aes_busy,
  input  logic        aes_start_req,
  output logic        aes_start_grant,
  output logic        load_done,
  output logic        cmd_err
`ifdef KEYLOAD_LOCK_EN
  ,
  input  logic        lock
`endif
);

  localparam logic [1:0] KSIZE_128 = 2'b00;
  localparam logic [1:0] KSIZE_192 = 2'b01;
  localparam logic [1:0] KSIZE_256 = 2'b10;

  // Enough to count up to 8*d words (the largest key).
  localparam int unsigned CntW = $clog2(8 * d + 1);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StStart,
    StStream,
    StWaitDone,
    StDone
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [1:0]        size_q;
  logic              inv_q;
  logic              cmd_err_q;
  logic              locked;
  logic              size_legal;
  logic [CntW-1:0]   last_idx;
  logic              word_hs;

`ifdef KEYLOAD_LOCK_EN
  logic lock_q;

  // Sticky lock bit; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= 1'b0;
    end else if (lock) begin
      lock_q <= 1'b1;
    end
  end

  assign locked = lock_q;
`else
  assign locked = 1'b0;
`endif

  assign size_legal = (cmd_key_size == KSIZE_128) || (cmd_key_size == KSIZE_192) ||
                      (cmd_key_size == KSIZE_256);
  assign word_hs    = (state_q == StStream) && key_valid && holder_data_in_ready;

  // Index of the final word: d shares of N words each, minus one.
  always_comb begin
    last_idx = CntW'(d * 4 - 1);
    case (size_q)
      KSIZE_192: last_idx = CntW'(d * 6 - 1);
      KSIZE_256: last_idx = CntW'(d * 8 - 1);
      default:   last_idx = CntW'(d * 4 - 1);
    endcase
  end

  // Load sequencer with latched command fields and the registered reject pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      size_q    <= KSIZE_128;
      inv_q     <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      cmd_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            if (!size_legal || locked) begin
              cmd_err_q <= 1'b1;
            end else begin
              size_q  <= cmd_key_size;
              inv_q   <= cmd_mode_inverse;
              cnt_q   <= '0;
              state_q <= StArm;
            end
          end
        end
        StArm: begin
          if (!holder_busy && !aes_busy) begin
            state_q <= StStart;
          end
        end
        StStart: begin
          state_q <= StStream;
        end
        StStream: begin
          if (word_hs) begin
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == last_idx) begin
              state_q <= StWaitDone;
            end
          end
        end
        StWaitDone: begin
          if (!holder_busy) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Outputs decoded straight from the state register, plus the stream pass-through.
  always_comb begin
    cmd_ready            = (state_q == StIdle);
    holder_start_fetch   = (state_q == StStart);
    load_done            = (state_q == StDone);
    cmd_err              = cmd_err_q;
    holder_key_size_cfg  = size_q;
    holder_mode_inverse  = inv_q;
    holder_data_in       = (state_q == StStream) ? key_data : 32'h0;
    holder_data_in_valid = (state_q == StStream) && key_valid;
    key_ready            = (state_q == StStream) && holder_data_in_ready;
    // No AES start may collide with a fetch; inverse loads release one for the last key.
    aes_start_grant      = aes_start_req &&
                           (((state_q == StIdle) && !holder_busy) ||
                            ((state_q == StWaitDone) && holder_last_key_req));
  end

endmodule

// File: tb/tb_mskkey_load_ctrl.sv
// Directed self-checking bench for mskkey_load_ctrl (d = 2).
module tb_mskkey_load_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_key_size;
  logic        cmd_mode_inverse;
  logic [31:0] key_data;
  logic        key_valid;
  logic        key_ready;
  logic        holder_start_fetch;
  logic [1:0]  holder_key_size_cfg;
  logic        holder_mode_inverse;
  logic [31:0] holder_data_in;
  logic        holder_data_in_valid;
  logic        holder_data_in_ready;
  logic        holder_busy;
  logic        holder_last_key_req;
  logic        aes_busy;
  logic        aes_start_req;
  logic        aes_start_grant;
  logic        load_done;
  logic        cmd_err;
`ifdef KEYLOAD_LOCK_EN
  logic        lock;
`endif

  int checks = 0;
  int errors = 0;

  mskkey_load_ctrl #(.d(2)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_key_size         (cmd_key_size),
    .cmd_mode_inverse     (cmd_mode_inverse),
    .key_data             (key_data),
    .key_valid            (key_valid),
    .key_ready            (key_ready),
    .holder_start_fetch   (holder_start_fetch),
    .holder_key_size_cfg  (holder_key_size_cfg),
    .holder_mode_inverse  (holder_mode_inverse),
    .holder_data_in       (holder_data_in),
    .holder_data_in_valid (holder_data_in_valid),
    .holder_data_in_ready (holder_data_in_ready),
    .holder_busy          (holder_busy),
    .holder_last_key_req  (holder_last_key_req),
    .aes_busy             (aes_busy),
    .aes_start_req        (aes_start_req),
    .aes_start_grant      (aes_start_grant),
    .load_done            (load_done),
    .cmd_err              (cmd_err)
`ifdef KEYLOAD_LOCK_EN
    ,
    .lock                 (lock)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a command from IDLE, check ARM and START, enter STREAM with the holder busy.
  task automatic do_start(input logic [1:0] size, input logic inv);
    cmd_valid        = 1'b1;
    cmd_key_size     = size;
    cmd_mode_inverse = inv;
    #1;
    chk("idle_cmd_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    #1;
    chk("arm_cmd_ready", cmd_ready, 1'b0);
    chk("arm_no_start", holder_start_fetch, 1'b0);
    chkw("arm_size_cfg", 32'(holder_key_size_cfg), 32'(size));
    chk("arm_inverse", holder_mode_inverse, inv);
    tick();
    #1;
    chk("start_pulse", holder_start_fetch, 1'b1);
    chk("start_key_ready", key_ready, 1'b0);
    holder_busy = 1'b1;
    tick();
  endtask

  // Present n words; holder ready on odd cycles only. Stays in STREAM if n < W.
  task automatic stream(input int n, input int base);
    int idx;
    int cyc;
    logic rdy;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 4 * n + 4) begin
      rdy                  = cyc[0];
      key_valid            = 1'b1;
      key_data             = 32'hA500_0000 + 32'(base + idx);
      holder_data_in_ready = rdy;
      #1;
      chkw("fwd_data", holder_data_in, 32'hA500_0000 + 32'(base + idx));
      chk("fwd_valid", holder_data_in_valid, 1'b1);
      chk("fwd_key_ready", key_ready, rdy);
      chk("stream_no_start", holder_start_fetch, 1'b0);
      if (rdy) idx++;
      tick();
      cyc++;
    end
    chkw("stream_count", 32'(idx), 32'(n));
  endtask

  initial begin
    rst                  = 1'b1;
    cmd_valid            = 1'b0;
    cmd_key_size         = 2'b00;
    cmd_mode_inverse     = 1'b0;
    key_data             = 32'h0;
    key_valid            = 1'b0;
    holder_data_in_ready = 1'b0;
    holder_busy          = 1'b0;
    holder_last_key_req  = 1'b0;
    aes_busy             = 1'b0;
    aes_start_req        = 1'b0;
`ifdef KEYLOAD_LOCK_EN
    lock                 = 1'b0;
`endif
    tick();
    tick();
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_start", holder_start_fetch, 1'b0);
    chk("rst_load_done", load_done, 1'b0);
    chk("rst_cmd_err", cmd_err, 1'b0);
    chk("rst_key_ready", key_ready, 1'b0);
    chk("rst_hvalid", holder_data_in_valid, 1'b0);
    chkw("rst_size_cfg", 32'(holder_key_size_cfg), 32'h0);
    chk("rst_inverse", holder_mode_inverse, 1'b0);
    chk("rst_grant", aes_start_grant, 1'b0);
    rst = 1'b0;

    // Grant in IDLE depends on holder_busy.
    tick();
    aes_start_req = 1'b1;
    #1;
    chk("idle_grant", aes_start_grant, 1'b1);
    holder_busy = 1'b1;
    #1;
    chk("idle_grant_hbusy", aes_start_grant, 1'b0);
    aes_start_req = 1'b0;
    holder_busy   = 1'b0;

    // KSIZE_128 load: a word offered in IDLE is held, 8 words forwarded.
    key_valid            = 1'b1;
    key_data             = 32'hA500_0000;
    holder_data_in_ready = 1'b1;
    #1;
    chk("idle_word_held", key_ready, 1'b0);
    chk("idle_hvalid", holder_data_in_valid, 1'b0);
    do_start(2'b00, 1'b0);
    stream(8, 0);
    key_valid            = 1'b1;
    key_data             = 32'hA500_0008;
    holder_data_in_ready = 1'b1;
    #1;
    chk("word9_stalled", key_ready, 1'b0);
    chk("word9_hvalid", holder_data_in_valid, 1'b0);
    chk("wait_no_done", load_done, 1'b0);
    chk("wait_no_start", holder_start_fetch, 1'b0);
    tick();
    chk("wait_busy_no_done", load_done, 1'b0);
    holder_busy = 1'b0;
    tick();
    chk("load_done_128", load_done, 1'b1);
    tick();
    chk("done_pulse_ends", load_done, 1'b0);
    chk("back_idle", cmd_ready, 1'b1);
    key_valid = 1'b0;

    // KSIZE_256 inverse: grant released only under holder_last_key_req.
    do_start(2'b10, 1'b1);
    stream(16, 16);
    key_valid     = 1'b0;
    aes_start_req = 1'b1;
    #1;
    chk("wait_grant_nolast", aes_start_grant, 1'b0);
    holder_last_key_req = 1'b1;
    #1;
    chk("wait_grant_last", aes_start_grant, 1'b1);
    tick();
    chk("wait_grant_hold", aes_start_grant, 1'b1);
    chk("inv_no_done", load_done, 1'b0);
    holder_busy = 1'b0;
    tick();
    chk("load_done_256", load_done, 1'b1);
    chk("done_no_grant", aes_start_grant, 1'b0);
    chk("done_inverse", holder_mode_inverse, 1'b1);
    aes_start_req       = 1'b0;
    holder_last_key_req = 1'b0;
    tick();

    // Command together with a granted AES start; ARM waits for aes_busy.
    aes_start_req    = 1'b1;
    aes_busy         = 1'b1;
    cmd_valid        = 1'b1;
    cmd_key_size     = 2'b00;
    cmd_mode_inverse = 1'b0;
    #1;
    chk("same_cycle_grant", aes_start_grant, 1'b1);
    chk("same_cycle_ready", cmd_ready, 1'b1);
    tick();
    aes_start_req = 1'b0;
    cmd_valid     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("arm_stall_start", holder_start_fetch, 1'b0);
      chk("arm_stall_ready", cmd_ready, 1'b0);
      tick();
    end
    aes_busy = 1'b0;
    #1;
    chk("arm_release_start", holder_start_fetch, 1'b0);
    tick();
    chk("arm_late_start", holder_start_fetch, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_start", holder_start_fetch, 1'b0);
    chk("abort_idle", cmd_ready, 1'b1);

    // Illegal key size: reject pulse, no load.
    cmd_valid    = 1'b1;
    cmd_key_size = 2'b11;
    tick();
    cmd_valid = 1'b0;
    chk("illegal_err", cmd_err, 1'b1);
    chk("illegal_idle", cmd_ready, 1'b1);
    chk("illegal_no_start", holder_start_fetch, 1'b0);
    chkw("illegal_cfg", 32'(holder_key_size_cfg), 32'h0);
    tick();
    chk("illegal_err_ends", cmd_err, 1'b0);
    chk("illegal_no_start2", holder_start_fetch, 1'b0);
    chk("illegal_still_idle", cmd_ready, 1'b1);

    // KSIZE_192 interrupted after 5 of 12 words, then a clean KSIZE_128 load.
    do_start(2'b01, 1'b0);
    stream(5, 100);
    key_valid            = 1'b1;
    holder_data_in_ready = 1'b1;
    rst                  = 1'b1;
    holder_busy          = 1'b0;
    tick();
    rst = 1'b0;
    chk("mid_rst_ready", cmd_ready, 1'b1);
    chk("mid_rst_key_ready", key_ready, 1'b0);
    chk("mid_rst_hvalid", holder_data_in_valid, 1'b0);
    chkw("mid_rst_cfg", 32'(holder_key_size_cfg), 32'h0);
    chk("mid_rst_done", load_done, 1'b0);
    key_valid = 1'b0;
    do_start(2'b00, 1'b0);
    stream(8, 200);
    key_valid   = 1'b0;
    holder_busy = 1'b0;
    tick();
    chk("reload_done", load_done, 1'b1);
    tick();

`ifdef KEYLOAD_LOCK_EN
    // Locked: commands rejected until reset.
    lock = 1'b1;
    tick();
    lock         = 1'b0;
    cmd_valid    = 1'b1;
    cmd_key_size = 2'b00;
    tick();
    cmd_valid = 1'b0;
    chk("lock_err", cmd_err, 1'b1);
    chk("lock_idle", cmd_ready, 1'b1);
    tick();
    chk("lock_no_start", holder_start_fetch, 1'b0);
    chk("lock_still_idle", cmd_ready, 1'b1);
    aes_start_req = 1'b1;
    #1;
    chk("lock_grant", aes_start_grant, 1'b1);
    aes_start_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    do_start(2'b00, 1'b0);
    stream(8, 300);
    key_valid   = 1'b0;
    holder_busy = 1'b0;
    tick();
    chk("unlock_done", load_done, 1'b1);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
